// File: rtl/seg7_to_binary_decoder.sv
// Seven-segment receiver: waits for a stable segment pattern, then decodes
// it to a hex value (o_VALID strobe), flags illegal codes, or reports blank.
//
// Ports:
//   i_CLK, i_RST_N      clock, async active-low reset
//   i_SEG_0..i_SEG_6    segment lines a..g
//   o_BINARY            last decoded value, held between strobes
//   o_VALID / o_ERROR   one-cycle strobes: decoded / illegal pattern
//   o_BLANK / o_LOCKED  levels: locked on all-off / pattern locked
module seg7_to_binary_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_SEG_0,
  input  logic       i_SEG_1,
  input  logic       i_SEG_2,
  input  logic       i_SEG_3,
  input  logic       i_SEG_4,
  input  logic       i_SEG_5,
  input  logic       i_SEG_6,
  output logic [3:0] o_BINARY,
  output logic       o_VALID,
  output logic       o_ERROR,
  output logic       o_BLANK,
  output logic       o_LOCKED
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t      state, state_d;
  logic [CW-1:0] count, count_d;
  logic [6:0]  seg_raw;
  logic [6:0]  seg_cur;
  logic [6:0]  r_sample;
  logic        same;
  logic        lock_now;
  logic        dec_legal;
  logic [3:0]  dec_val;
  logic [3:0]  bin_d;
  logic        valid_d;
  logic        error_d;
  logic        blank_d;

  assign seg_raw = {i_SEG_6, i_SEG_5, i_SEG_4, i_SEG_3,
                    i_SEG_2, i_SEG_1, i_SEG_0};
  assign seg_cur = seg_raw ^ {7{ACTIVE_LOW}};

  assign same     = (seg_cur == r_sample);
  assign lock_now = (state == SETTLING) && same
                    && (count == LAST);

  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'h0;
    unique case (seg_cur)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state    <= SETTLING;
      count    <= '0;
      r_sample <= 7'h00;
    end else begin
      state    <= state_d;
      count    <= count_d;
      r_sample <= seg_cur;
    end
  end

  // Count is frozen once locked, so it tops out at STABLE_CYCLES.
  always_comb begin
    state_d = state;
    count_d = count;
    if (!same) begin
      state_d = SETTLING;
      count_d = '0;
    end else if (state == SETTLING) begin
      count_d = count + CW'(1);
      if (count == LAST) state_d = LOCKED;
    end
  end

  // All-off is checked first: it is not a legal hex code.
  always_comb begin
    bin_d   = o_BINARY;
    valid_d = 1'b0;
    error_d = 1'b0;
    blank_d = o_BLANK;
    if (!same) begin
      blank_d = 1'b0;
    end else if (lock_now) begin
      if (seg_cur == 7'h00) begin
        blank_d = 1'b1;
      end else if (dec_legal) begin
        bin_d   = dec_val;
        valid_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_BINARY <= 4'h0;
      o_VALID  <= 1'b0;
      o_ERROR  <= 1'b0;
      o_BLANK  <= 1'b0;
    end else begin
      o_BINARY <= bin_d;
      o_VALID  <= valid_d;
      o_ERROR  <= error_d;
      o_BLANK  <= blank_d;
    end
  end

  assign o_LOCKED = (state == LOCKED);

endmodule
